// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  // Widest operand the absolute-value helper handles; callers sign-extend into it.
  localparam int unsigned MAX_WIDTH = 64;

  function automatic logic [MAX_WIDTH-1:0] absVal(input logic [MAX_WIDTH-1:0] v);
    return v[MAX_WIDTH-1] ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// Combinational single iteration: MUL_BITS-wide shift-add, or one restoring-divide bit.
// Divider path present only when MULDIV_DIV_EN is defined.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_BITS = 1
) (
`ifdef MULDIV_DIV_EN
  input  logic                 isDiv,
`endif
  input  logic [WIDTH-1:0]     operand,
  input  logic [2*WIDTH-1:0]   accIn,
  output logic [2*WIDTH-1:0]   accOut
);

  logic [WIDTH+MUL_BITS-1:0]   partial;
  logic [WIDTH+MUL_BITS-1:0]   sum;
  logic [2*WIDTH+MUL_BITS-1:0] wide;
  logic [2*WIDTH-1:0]          mulOut;

  // acc = {running product high half, remaining multiplier bits}; shifts right each step
  always_comb begin
    partial = '0;
    for (int unsigned i = 0; i < MUL_BITS; i++) begin
      if (accIn[i]) partial = partial + ({{MUL_BITS{1'b0}}, operand} << i);
    end
    sum    = partial + {{MUL_BITS{1'b0}}, accIn[2*WIDTH-1:WIDTH]};
    wide   = {sum, accIn[WIDTH-1:0]};
    mulOut = (2*WIDTH)'(wide >> MUL_BITS);
  end

`ifdef MULDIV_DIV_EN
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] divOut;

  // acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}
  always_comb begin
    diff   = {1'b0, accIn[2*WIDTH-1:WIDTH-1]} - {2'b00, operand};
    divOut = diff[WIDTH+1] ? {accIn[2*WIDTH-2:0], 1'b0}
                           : {WIDTH'(diff), accIn[WIDTH-2:0], 1'b1};
    accOut = isDiv ? divOut : mulOut;
  end
`else
  assign accOut = mulOut;
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit with busy/stall handshake to the hazard unit.
// Define MULDIV_DIV_EN to include DIV/DIVU; otherwise they are accepted as no-ops.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             abort,
  output logic             req_ready,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned    CNT_W   = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] MUL_CYC = CNT_W'(WIDTH / MUL_BITS);
`ifdef MULDIV_DIV_EN
  localparam logic [CNT_W-1:0] DIV_CYC = CNT_W'(WIDTH);
`endif

  state_t             state, stateNext;
  logic [2*WIDTH-1:0] acc, accStep;
  logic [WIDTH-1:0]   operand;
  logic [CNT_W-1:0]   cnt;
  logic               negRes;
`ifdef MULDIV_DIV_EN
  logic               negRem, divZero, opDiv;
`endif

  logic               signedOp;
  logic [WIDTH-1:0]   absA, absB, opA, opB;

  assign signedOp = (req_op == MULT) || (req_op == DIV);
  assign absA     = WIDTH'(absVal(MAX_WIDTH'($signed(req_a))));
  assign absB     = WIDTH'(absVal(MAX_WIDTH'($signed(req_b))));
  assign opA      = signedOp ? absA : req_a;
  assign opB      = signedOp ? absB : req_b;

  assign busy      = (state != S_IDLE);
  assign req_ready = ~busy;
  assign stall_req = busy | (req_valid & ~req_ready);

  muldiv_step #(
    .WIDTH    (WIDTH),
    .MUL_BITS (MUL_BITS)
  ) u_step (
`ifdef MULDIV_DIV_EN
    .isDiv   (state == S_DIV),
`endif
    .operand (operand),
    .accIn   (acc),
    .accOut  (accStep)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_op == MULT || req_op == MULTU) stateNext = S_MUL;
`ifdef MULDIV_DIV_EN
          else if (req_op == DIV || req_op == DIVU) stateNext = S_DIV;
`endif
        end
      end
      S_MUL:   if (cnt == CNT_W'(1)) stateNext = S_FIX;
`ifdef MULDIV_DIV_EN
      S_DIV:   if (cnt == CNT_W'(1)) stateNext = S_FIX;
`endif
      S_FIX:   stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
    if (abort && state != S_IDLE) stateNext = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi      <= '0;
      lo      <= '0;
      acc     <= '0;
      operand <= '0;
      cnt     <= '0;
      negRes  <= 1'b0;
`ifdef MULDIV_DIV_EN
      negRem  <= 1'b0;
      divZero <= 1'b0;
      opDiv   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            case (req_op)
              MULT, MULTU: begin
                acc     <= {{WIDTH{1'b0}}, opB};
                operand <= opA;
                cnt     <= MUL_CYC;
                negRes  <= signedOp & (req_a[WIDTH-1] ^ req_b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
                opDiv   <= 1'b0;
`endif
              end
`ifdef MULDIV_DIV_EN
              DIV, DIVU: begin
                acc     <= {{WIDTH{1'b0}}, opA};
                operand <= opB;
                cnt     <= DIV_CYC;
                negRes  <= signedOp & (req_a[WIDTH-1] ^ req_b[WIDTH-1]);
                negRem  <= signedOp & req_a[WIDTH-1];
                divZero <= (req_b == '0);
                opDiv   <= 1'b1;
              end
`endif
              MTHI:    hi <= req_a;
              MTLO:    lo <= req_a;
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          acc <= accStep;
          cnt <= cnt - CNT_W'(1);
        end
        S_FIX: begin
          // Divide by zero leaves remainder = |a|; the dividend-sign fixup restores HI = a.
          if (!abort) begin
`ifdef MULDIV_DIV_EN
            if (opDiv) begin
              hi <= negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
              lo <= divZero ? '1 : (negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
            end else
`endif
            {hi, lo} <= negRes ? -acc : acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
